// File: rtl/dma_tx_pkg.sv
// rtl/dma_tx_pkg.sv - shared types and constants for the TX channel dispatcher
package dma_tx_pkg;

    // Skid entries are sized for the widest supported channel ID and beat.
    localparam int TX_CID_W  = 8;
    localparam int TX_DATA_W = 512;

    localparam int ERR_BAD_CID    = 0;
    localparam int ERR_SOP_IN_PKT = 1;
    localparam int ERR_CRD_OVF    = 2;

    typedef struct packed {
        logic [TX_CID_W-1:0]  cid;
        logic                 sop;
        logic                 eop;
        logic [TX_DATA_W-1:0] data;
    } tx_beat_t;

    typedef enum logic [1:0] {
        IDLE,
        PKT,
        DROP
    } tx_disp_state_e;

endpackage

// File: rtl/dma_tx_credit_ctr.sv
// rtl/dma_tx_credit_ctr.sv - per-channel saturating packet credit counter
module dma_tx_credit_ctr
    import dma_tx_pkg::*;
#(
    parameter int CREDIT_MAX = 8,
    parameter int CRD_WIDTH  = $clog2(CREDIT_MAX + 1)
) (
    input  logic                 user_clk,
    input  logic                 reset,
    input  logic                 consume,
    input  logic                 credit_ret,
    output logic [CRD_WIDTH-1:0] count,
    output logic                 ovf
);

    localparam logic [CRD_WIDTH-1:0] CRD_FULL = CRD_WIDTH'(CREDIT_MAX);

    // A return at full credit is dropped and reported; a simultaneous consume cancels it.
    assign ovf = credit_ret & ~consume & (count == CRD_FULL);

    always_ff @(posedge user_clk) begin
        if (reset) begin
            count <= CRD_FULL;
        end else begin
            case ({consume, credit_ret})
                2'b10: if (count != '0) count <= count - 1'b1;
                2'b01: if (count != CRD_FULL) count <= count + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/dma_tx_ch_dispatch.sv
// rtl/dma_tx_ch_dispatch.sv - dispatches a channel-tagged TX beat stream to per-channel queues
module dma_tx_ch_dispatch
    import dma_tx_pkg::*;
#(
    parameter int CH_NUM     = 32,
    parameter int CID_WIDTH  = $clog2(CH_NUM),
    parameter int DATA_WIDTH = 512,
    parameter int CREDIT_MAX = 8,
    parameter int CRD_WIDTH  = $clog2(CREDIT_MAX + 1)
) (
    input  logic                             user_clk,
    input  logic                             reset,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [CID_WIDTH-1:0]             s_cid,
    input  logic                             s_sop,
    input  logic                             s_eop,
    input  logic [DATA_WIDTH-1:0]            s_data,
    output logic [CH_NUM-1:0]                m_chx_valid,
    input  logic [CH_NUM-1:0]                m_chx_ready,
    output logic                             m_sop,
    output logic                             m_eop,
    output logic [DATA_WIDTH-1:0]            m_data,
    input  logic [CH_NUM-1:0]                chx_credit_ret,
    output logic [CH_NUM-1:0][CRD_WIDTH-1:0] chx_credit,
    output logic [2:0]                       err_status
);

    tx_disp_state_e       state_q, state_d;
    logic [CID_WIDTH-1:0] cur_cid_q, cur_cid_d;
    tx_beat_t             skid_q [2];
    logic [1:0]           skid_cnt_q;
    tx_beat_t             head, push_beat;
    logic                 push, pop, accept, cid_ok, crd_stall, skid_nonempty;
    logic [CH_NUM-1:0]    consume, crd_zero, crd_ovf;
    logic [2:0]           err_set;

    assign cid_ok = {1'b0, s_cid} < (CID_WIDTH + 1)'(CH_NUM);

    for (genvar i = 0; i < CH_NUM; i++) begin : g_crd
        dma_tx_credit_ctr #(
            .CREDIT_MAX (CREDIT_MAX),
            .CRD_WIDTH  (CRD_WIDTH)
        ) u_ctr (
            .user_clk   (user_clk),
            .reset      (reset),
            .consume    (consume[i]),
            .credit_ret (chx_credit_ret[i]),
            .count      (chx_credit[i]),
            .ovf        (crd_ovf[i])
        );
        assign crd_zero[i] = (chx_credit[i] == '0);
    end

    // Only a fresh SOP to a creditless channel stalls; continuation beats never do.
    assign crd_stall = (state_q == IDLE) & s_valid & s_sop & cid_ok
                     & |(crd_zero & (CH_NUM'(1) << s_cid));
    assign s_ready   = ~reset & (skid_cnt_q != 2'd2) & ~crd_stall;
    assign accept    = s_valid & s_ready;

    always_comb begin
        state_d   = state_q;
        cur_cid_d = cur_cid_q;
        push      = 1'b0;
        consume   = '0;
        err_set   = '0;
        err_set[ERR_CRD_OVF] = |crd_ovf;
        push_beat = '{cid: TX_CID_W'(s_cid), sop: s_sop, eop: s_eop, data: TX_DATA_W'(s_data)};
        case (state_q)
            IDLE: if (accept) begin
                if (!s_sop) begin
                    err_set[ERR_SOP_IN_PKT] = 1'b1;
                end else if (!cid_ok) begin
                    err_set[ERR_BAD_CID] = 1'b1;
                    if (!s_eop) state_d = DROP;
                end else begin
                    cur_cid_d = s_cid;
                    consume   = CH_NUM'(1) << s_cid;
                    push      = 1'b1;
                    if (!s_eop) state_d = PKT;
                end
            end
            PKT: if (accept) begin
                push          = 1'b1;
                push_beat.cid = TX_CID_W'(cur_cid_q);
                push_beat.sop = 1'b0;
                if (s_sop) err_set[ERR_SOP_IN_PKT] = 1'b1;
                if (s_eop) state_d = IDLE;
            end
            DROP: if (accept && s_eop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge user_clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cur_cid_q  <= '0;
            err_status <= '0;
        end else begin
            state_q    <= state_d;
            cur_cid_q  <= cur_cid_d;
            err_status <= err_status | err_set;
        end
    end

    assign head          = skid_q[0];
    assign skid_nonempty = (skid_cnt_q != 2'd0);
    assign m_chx_valid   = skid_nonempty ? (CH_NUM'(1) << head.cid) : '0;
    assign m_sop         = skid_nonempty & head.sop;
    assign m_eop         = skid_nonempty & head.eop;
    assign m_data        = skid_nonempty ? head.data[DATA_WIDTH-1:0] : '0;
    assign pop           = |(m_chx_valid & m_chx_ready);

    always_ff @(posedge user_clk) begin
        if (reset) begin
            skid_cnt_q <= '0;
            skid_q[0]  <= '0;
            skid_q[1]  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (skid_cnt_q == 2'd0) skid_q[0] <= push_beat;
                    else                    skid_q[1] <= push_beat;
                    skid_cnt_q <= skid_cnt_q + 2'd1;
                end
                2'b01: begin
                    skid_q[0]  <= skid_q[1];
                    skid_cnt_q <= skid_cnt_q - 2'd1;
                end
                2'b11: begin
                    if (skid_cnt_q == 2'd1) begin
                        skid_q[0] <= push_beat;
                    end else begin
                        skid_q[0] <= skid_q[1];
                        skid_q[1] <= push_beat;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_tx_ch_dispatch.sv
// tb/tb_dma_tx_ch_dispatch.sv - self-checking bench for dma_tx_ch_dispatch
module tb_dma_tx_ch_dispatch;

    localparam int CH_NUM     = 32;
    localparam int CID_WIDTH  = 6;
    localparam int DATA_WIDTH = 512;
    localparam int CREDIT_MAX = 8;
    localparam int CRD_WIDTH  = 4;

    logic                             user_clk = 1'b0;
    logic                             reset;
    logic                             s_valid, s_ready, s_sop, s_eop;
    logic [CID_WIDTH-1:0]             s_cid;
    logic [DATA_WIDTH-1:0]            s_data;
    logic [CH_NUM-1:0]                m_chx_valid, m_chx_ready, chx_credit_ret;
    logic                             m_sop, m_eop;
    logic [DATA_WIDTH-1:0]            m_data;
    logic [CH_NUM-1:0][CRD_WIDTH-1:0] chx_credit;
    logic [2:0]                       err_status;

    int checks   = 0;
    int failures = 0;

    dma_tx_ch_dispatch #(
        .CH_NUM     (CH_NUM),
        .CID_WIDTH  (CID_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .CREDIT_MAX (CREDIT_MAX),
        .CRD_WIDTH  (CRD_WIDTH)
    ) dut (
        .user_clk       (user_clk),
        .reset          (reset),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_cid          (s_cid),
        .s_sop          (s_sop),
        .s_eop          (s_eop),
        .s_data         (s_data),
        .m_chx_valid    (m_chx_valid),
        .m_chx_ready    (m_chx_ready),
        .m_sop          (m_sop),
        .m_eop          (m_eop),
        .m_data         (m_data),
        .chx_credit_ret (chx_credit_ret),
        .chx_credit     (chx_credit),
        .err_status     (err_status)
    );

    always #5 user_clk = ~user_clk;

    typedef struct {
        logic        v;
        logic        sop;
        logic        eop;
        logic [5:0]  cid;
        logic [31:0] d;
        logic        exp_rdy;
        logic [31:0] exp_vld;
        logic        exp_sop;
        logic        exp_eop;
        logic [31:0] exp_d;
    } vec_t;

    vec_t vt [7];
    logic [DATA_WIDTH-1:0] pd [4];
    logic [DATA_WIDTH-1:0] got [$];

    task automatic chk(input string name, input logic [DATA_WIDTH-1:0] act,
                       input logic [DATA_WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge user_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic send(input logic sop, input logic eop, input logic [CID_WIDTH-1:0] cid,
                        input logic [DATA_WIDTH-1:0] d);
        int n = 0;
        s_valid = 1'b1; s_sop = sop; s_eop = eop; s_cid = cid; s_data = d;
        settle();
        while (!s_ready && n < 40) begin
            step();
            n++;
        end
        if (!s_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: s_ready stayed %0b for cid %0d, needed 1", s_ready, cid);
        end
        step();
        s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
    endtask

    initial begin
        reset = 1'b1; s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0; s_cid = '0; s_data = '0;
        m_chx_ready = '1; chx_credit_ret = '0;
        step();
        step();
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_chx_valid, 0);
        chk("rst_m_sop", m_sop, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_err", err_status, 0);
        for (int i = 0; i < CH_NUM; i++) chk($sformatf("rst_credit%0d", i), chx_credit[i], CREDIT_MAX);
        reset = 1'b0;
        settle();
        chk("post_rst_s_ready", s_ready, 1);

        // 3-beat packet to cid 5, then single-beat packet to the top channel.
        vt[0] = '{1, 1, 0, 6'd5,  32'hA1, 1, 32'h0,        0, 0, 32'h0};
        vt[1] = '{1, 0, 0, 6'd5,  32'hA2, 1, 32'h20,       1, 0, 32'hA1};
        vt[2] = '{1, 0, 1, 6'd5,  32'hA3, 1, 32'h20,       0, 0, 32'hA2};
        vt[3] = '{0, 0, 0, 6'd0,  32'h0,  1, 32'h20,       0, 1, 32'hA3};
        vt[4] = '{1, 1, 1, 6'd31, 32'hB1, 1, 32'h0,        0, 0, 32'h0};
        vt[5] = '{0, 0, 0, 6'd0,  32'h0,  1, 32'h80000000, 1, 1, 32'hB1};
        vt[6] = '{0, 0, 0, 6'd0,  32'h0,  1, 32'h0,        0, 0, 32'h0};
        for (int i = 0; i < 7; i++) begin
            s_valid = vt[i].v; s_sop = vt[i].sop; s_eop = vt[i].eop;
            s_cid = vt[i].cid; s_data = DATA_WIDTH'(vt[i].d);
            settle();
            chk($sformatf("vec%0d_s_ready", i), s_ready, vt[i].exp_rdy);
            chk($sformatf("vec%0d_m_valid", i), m_chx_valid, vt[i].exp_vld);
            chk($sformatf("vec%0d_m_sop", i), m_sop, vt[i].exp_sop);
            chk($sformatf("vec%0d_m_eop", i), m_eop, vt[i].exp_eop);
            chk($sformatf("vec%0d_m_data", i), m_data, DATA_WIDTH'(vt[i].exp_d));
            step();
        end
        s_valid = 1'b0;
        chk("credit5_after_pkt", chx_credit[5], 7);
        chk("credit31_after_pkt", chx_credit[31], 7);

        // Exhaust channel 2, stall the 9th SOP, release with one credit return.
        for (int i = 0; i < 8; i++) send(1, 1, 2, DATA_WIDTH'(i));
        chk("credit2_empty", chx_credit[2], 0);
        s_valid = 1'b1; s_sop = 1'b1; s_eop = 1'b1; s_cid = 2; s_data = 'h99;
        settle();
        chk("stall_s_ready", s_ready, 0);
        step();
        chk("stall_s_ready2", s_ready, 0);
        chk("stall_no_delivery", m_chx_valid, 0);
        chx_credit_ret = 32'h4;
        step();
        chx_credit_ret = '0;
        settle();
        chk("ret_credit2", chx_credit[2], 1);
        chk("ret_s_ready", s_ready, 1);
        step();
        s_valid = 1'b0;
        chk("ninth_m_valid", m_chx_valid, 32'h4);
        chk("ninth_m_data", m_data, 'h99);
        chk("credit2_back_to_0", chx_credit[2], 0);
        step();

        // Backpressure on channel 3 during a 4-beat packet.
        for (int i = 0; i < 4; i++) pd[i] = DATA_WIDTH'(32'hC0 + i);
        m_chx_ready = ~32'h8;
        s_valid = 1'b1; s_sop = 1'b1; s_eop = 1'b0; s_cid = 3; s_data = pd[0];
        settle();
        chk("bp_beat0_ready", s_ready, 1);
        step();
        s_sop = 1'b0; s_data = pd[1];
        settle();
        chk("bp_beat1_ready", s_ready, 1);
        step();
        s_data = pd[2];
        settle();
        chk("bp_full_s_ready", s_ready, 0);
        chk("bp_full_m_valid", m_chx_valid, 32'h8);
        chk("bp_full_m_data", m_data, pd[0]);
        step();
        chk("bp_full_s_ready2", s_ready, 0);
        chk("bp_full_m_data2", m_data, pd[0]);
        m_chx_ready = '1;
        begin
            int idx = 2;
            logic acc, pp;
            got.delete();
            for (int c = 0; c < 20 && got.size() < 4; c++) begin
                s_valid = (idx < 4);
                s_data  = pd[(idx < 4) ? idx : 0];
                s_eop   = (idx == 3);
                settle();
                acc = s_valid & s_ready;
                pp  = |(m_chx_valid & m_chx_ready);
                if (pp) got.push_back(m_data);
                step();
                if (acc) idx++;
            end
        end
        s_valid = 1'b0; s_eop = 1'b0;
        settle();
        chk("bp_beat_count", got.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("bp_order%0d", i), (i < got.size()) ? got[i] : '0, pd[i]);
        chk("bp_no_dup", m_chx_valid, 0);
        chk("credit3_after_bp", chx_credit[3], 7);

        // Out-of-range channel ID is dropped and flagged.
        send(1, 0, 40, 'hBAD0);
        chk("badcid_beat0_m_valid", m_chx_valid, 0);
        send(0, 1, 40, 'hBAD1);
        chk("badcid_beat1_m_valid", m_chx_valid, 0);
        chk("badcid_err", err_status, 3'b001);
        send(1, 1, 0, 'hD0);
        chk("after_bad_m_valid", m_chx_valid, 32'h1);
        chk("after_bad_m_data", m_data, 'hD0);
        chk("after_bad_m_sop", m_sop, 1);
        step();

        // Credit return at full count saturates and sets the overflow flag.
        chx_credit_ret = 32'h80;
        step();
        chx_credit_ret = '0;
        settle();
        chk("ovf_credit7", chx_credit[7], 8);
        chk("ovf_err", err_status, 3'b101);

        // Simultaneous consume and return on channel 1.
        send(1, 1, 1, 'h11);
        chk("credit1_pre", chx_credit[1], 7);
        step();
        s_valid = 1'b1; s_sop = 1'b1; s_eop = 1'b1; s_cid = 1; s_data = 'h12;
        chx_credit_ret = 32'h2;
        settle();
        chk("both_s_ready", s_ready, 1);
        step();
        s_valid = 1'b0; chx_credit_ret = '0;
        chk("both_credit1", chx_credit[1], 7);
        chk("both_m_valid", m_chx_valid, 32'h2);
        chk("both_err", err_status, 3'b101);

        // Non-SOP beat in IDLE, then a SOP inside a packet.
        send(0, 1, 0, 'hE0);
        chk("nosop_discard", m_chx_valid, 0);
        chk("nosop_err", err_status, 3'b111);
        send(1, 0, 4, 'hF0);
        send(1, 0, 6, 'hF1);
        chk("sopinpkt_m_valid", m_chx_valid, 32'h10);
        chk("sopinpkt_m_sop", m_sop, 0);
        chk("sopinpkt_m_data", m_data, 'hF1);
        send(0, 1, 6, 'hF2);
        chk("sopinpkt_eop_valid", m_chx_valid, 32'h10);
        chk("sopinpkt_eop", m_eop, 1);
        chk("sopinpkt_credit4", chx_credit[4], 7);
        chk("sopinpkt_credit6", chx_credit[6], 8);
        step();

        // Reset during beat 2 of a 5-beat packet.
        send(1, 0, 9, 'h90);
        s_valid = 1'b1; s_sop = 1'b0; s_data = 'h91;
        reset = 1'b1;
        settle();
        step();
        for (int i = 0; i < CH_NUM; i++) chk($sformatf("midrst_credit%0d", i), chx_credit[i], CREDIT_MAX);
        chk("midrst_m_valid", m_chx_valid, 0);
        chk("midrst_err", err_status, 0);
        chk("midrst_s_ready", s_ready, 0);
        reset = 1'b0; s_valid = 1'b0;
        step();
        send(1, 1, 9, 'h92);
        chk("restart_m_valid", m_chx_valid, 32'h200);
        chk("restart_m_sop", m_sop, 1);
        chk("restart_m_data", m_data, 'h92);
        chk("restart_credit9", chx_credit[9], 7);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
